// File: rtl/io_bus_arbiter_pkg.sv
// rtl/io_bus_arbiter_pkg.sv - shared widths, ctrl bit positions, FSM encoding and round-robin helper
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif

package io_bus_arbiter_pkg;

  localparam int IO_N_MST_DEF   = 2;
  localparam int IO_ADDR_W_DEF  = `IO_BUS_WIDTH_ADDR;
  localparam int IO_DATA_W_DEF  = `IO_BUS_WIDTH_DATA;
  localparam int IO_CTRL_W_DEF  = `IO_BUS_WIDTH_CTRL;
  localparam int IO_TIMEOUT_DEF = 255;

  localparam int CTRL_WRITE = 0;
  localparam int CTRL_READ  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Next search start after granting master k among n masters.
  function automatic int rr_next(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - master-side request/response and device-bus signals of the arbiter
interface io_bus_arbiter_if
  import io_bus_arbiter_pkg::*;
#(
  parameter int N_MST  = IO_N_MST_DEF,
  parameter int ADDR_W = IO_ADDR_W_DEF,
  parameter int DATA_W = IO_DATA_W_DEF,
  parameter int CTRL_W = IO_CTRL_W_DEF
);

  logic [N_MST-1:0]        m_req;
  logic [N_MST*ADDR_W-1:0] m_addr;
  logic [N_MST*CTRL_W-1:0] m_ctrl;
  logic [N_MST*DATA_W-1:0] m_wdata;
  logic [N_MST-1:0]        m_gnt;
  logic [N_MST-1:0]        m_done;
  logic                    m_err;
  logic [DATA_W-1:0]       m_rdata;

  logic                    bus_BC;
  logic [ADDR_W-1:0]       bus_addr;
  logic [CTRL_W-1:0]       bus_ctrl;
  logic [DATA_W-1:0]       bus_wdata;
  logic [DATA_W-1:0]       bus_rdata;
  logic                    bus_rdy;

  // slave: the arbiter itself; master: requesters plus device, as seen from outside.
  modport slave (
    input  m_req, m_addr, m_ctrl, m_wdata, bus_rdata, bus_rdy,
    output m_gnt, m_done, m_err, m_rdata, bus_BC, bus_addr, bus_ctrl, bus_wdata
  );

  modport master (
    output m_req, m_addr, m_ctrl, m_wdata, bus_rdata, bus_rdy,
    input  m_gnt, m_done, m_err, m_rdata, bus_BC, bus_addr, bus_ctrl, bus_wdata
  );

endinterface

// File: rtl/io_bus_arbiter_rr_pick.sv
// rtl/io_bus_arbiter_rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin arbiter granting N_MST masters one device-bus access at a time
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int N_MST   = IO_N_MST_DEF,
  parameter int ADDR_W  = IO_ADDR_W_DEF,
  parameter int DATA_W  = IO_DATA_W_DEF,
  parameter int CTRL_W  = IO_CTRL_W_DEF,
  parameter int TIMEOUT = IO_TIMEOUT_DEF
) (
  input logic             clk,
  input logic             rst,
  io_bus_arbiter_if.slave io
);

  localparam int IDX_W = $clog2(N_MST);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t state, state_nx;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_MST-1:0]  pick_gnt;
  logic              pick_any;
  logic [N_MST-1:0]  gnt_q;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] sel_addr;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [DATA_W-1:0] sel_wdata;
  logic              timeout_hit;
  logic              bc;
  logic [N_MST-1:0]  done;

  rr_pick #(
    .N    (N_MST),
    .IDX_W(IDX_W)
  ) u_pick (
    .req(io.m_req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_ctrl  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr  = io.m_addr[i*ADDR_W +: ADDR_W];
        sel_ctrl  = io.m_ctrl[i*CTRL_W +: CTRL_W];
        sel_wdata = io.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bc       = 1'b0;
    done     = '0;
    case (state)
      ST_IDLE: begin
        if (pick_any) state_nx = ST_ACCESS;
      end
      ST_ACCESS: begin
        bc = 1'b1;
        if (io.bus_rdy || timeout_hit) state_nx = ST_RESP;
      end
      ST_RESP: begin
        done     = gnt_q;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // The device sees only the values latched at grant; master inputs are ignored afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      gnt_q   <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      ctrl_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pick_any) begin
            gnt_q   <= pick_gnt;
            addr_q  <= sel_addr;
            ctrl_q  <= sel_ctrl;
            wdata_q <= sel_wdata;
            ptr     <= IDX_W'(rr_next(int'(pick_idx), N_MST));
          end
        end
        ST_ACCESS: begin
          if (io.bus_rdy) begin
            rdata_q <= io.bus_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          gnt_q <= '0;
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  assign io.m_gnt     = gnt_q;
  assign io.m_done    = done;
  assign io.m_err     = err_q;
  assign io.m_rdata   = rdata_q;
  assign io.bus_BC    = bc;
  assign io.bus_addr  = addr_q;
  assign io.bus_ctrl  = bc ? ctrl_q : '0;
  assign io.bus_wdata = wdata_q;

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_MST, default 2, meaning the number of bus masters (2..4).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the IO bus address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the IO bus data width.
REQ-004 The block SHALL have parameter CTRL_W, default 4, meaning the IO bus control width (bit0 = write, bit1 = read).
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ACCESS cycles before abort.
REQ-006 The block SHALL have port clk, input, 1, the single clock (all logic on rising edge).
REQ-007 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-008 The block SHALL have port m_req, input, N_MST, the per-master request level, held until m_done.
REQ-009 The block SHALL have port m_addr, input, N_MST*ADDR_W, the per-master address, packed with master 0 in the LSBs.
REQ-010 The block SHALL have port m_ctrl, input, N_MST*CTRL_W, the per-master control.
REQ-011 The block SHALL have port m_wdata, input, N_MST*DATA_W, the per-master write data.
REQ-012 The block SHALL have port m_gnt, output, N_MST, one-hot, high for the whole transaction of the owning master.
REQ-013 The block SHALL have port m_done, output, N_MST, a 1-cycle completion pulse to the owner.
REQ-014 The block SHALL have port m_err, output, 1, valid with m_done: 1 = timeout abort.
REQ-015 The block SHALL have port m_rdata, output, DATA_W, read data, valid with m_done.
REQ-016 The block SHALL have port bus_BC, output, 1, the bus query/transaction-active strobe to the device bus.
REQ-017 The block SHALL have ports bus_addr, bus_ctrl, bus_wdata, outputs, ADDR_W/CTRL_W/DATA_W, driven from the latched request.
REQ-018 The block SHALL have port bus_rdata, input, DATA_W, the device read data.
REQ-019 The block SHALL have port bus_rdy, input, 1, device completion, sampled only in ACCESS.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-021 IDLE: if any m_req bit is set, the block SHALL select a winner by round-robin starting at ptr, latch its addr/ctrl/wdata, set m_gnt, and go to ACCESS next cycle.
REQ-022 Round-robin: after a grant to master k, ptr SHALL become (k+1) mod N_MST; the search order is ptr, ptr+1, ... wrapping.
REQ-023 ACCESS: bus_BC SHALL be 1 and bus_addr/bus_ctrl/bus_wdata SHALL hold the latched values and be stable for the whole state.
REQ-024 ACCESS: bus_rdy=1 SHALL capture bus_rdata into m_rdata, clear err, and move to RESP.
REQ-025 ACCESS: a cycle counter SHALL start at 0 on entry; when it reaches TIMEOUT with bus_rdy=0, the block SHALL set err=1, set m_rdata=0, and move to RESP.
REQ-026 bus_rdy and timeout in the same cycle SHALL be treated as success (bus_rdy wins).
REQ-027 RESP: m_done[owner] SHALL be 1 for exactly one cycle; m_gnt SHALL clear at exit; next state SHALL be IDLE.
REQ-028 Minimum transaction latency SHALL be 3 cycles (req seen in IDLE -> m_done), with no IDLE turnaround wait beyond one cycle between grants.
REQ-029 Requests deasserted before grant SHALL be ignored; m_req changes after grant SHALL NOT affect the latched transaction.
REQ-030 Outside ACCESS: bus_BC=0, bus_ctrl=0; bus_addr/bus_wdata SHALL hold their last values.
REQ-031 The latched ctrl with neither read nor write bit SHALL still run a full ACCESS (device decides); no special case.

Reset
REQ-032 On rst=1 (any time, including mid-ACCESS) the block SHALL asynchronously go to IDLE, with ptr=0, m_gnt=0, m_done=0, m_err=0, m_rdata=0, bus_BC=0, bus_addr=0, bus_ctrl=0, bus_wdata=0, and counter=0.
REQ-033 An aborted transaction SHALL produce no m_done; masters SHALL reissue.

Structure
REQ-034 State encoding, the ctrl bit positions (WRITE=0, READ=1) and the default widths SHALL live in the shared parameter file alongside IO_BUS_WIDTH_* macros.
REQ-035 Round-robin winner selection SHALL be one sub-module, rr_pick (inputs req, ptr; outputs one-hot gnt, index, any).

Verification
REQ-036 Single read: m_req=01, addr 0xFFFFF000, ctrl=READ; bus_rdy on 2nd ACCESS cycle with bus_rdata=0x12345678 -> m_done[0] pulses with m_rdata=0x12345678, m_err=0, bus_BC high exactly 2 cycles.
REQ-037 Contention: m_req=11 continuously from reset, bus_rdy=1 immediately -> grants alternate 0,1,0,1; each m_done spaced 3 cycles.
REQ-038 Timeout: write with bus_rdy=0 permanently, TIMEOUT=4 -> m_done with m_err=1 and m_rdata=0 after 5 ACCESS cycles; next request is served normally.
REQ-039 Reset mid-ACCESS: rst at ACCESS cycle 2 -> all outputs 0 within same cycle, no m_done; after release, pending m_req=10 is granted to master 1 (ptr=0 search).
REQ-040 Simultaneous bus_rdy and timeout at counter=TIMEOUT -> m_err=0 and m_rdata equals bus_rdata.
